// File: rtl/nibble_serial_add_ctrl_pkg.sv
// rtl/nibble_serial_add_ctrl_pkg.sv - shared state encodings and nibble width for the serial adder
package nibble_serial_add_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_add_ctrl_nibble_add4.sv
// rtl/nibble_serial_add_ctrl_nibble_add4.sv - combinational 4-bit adder with carry in/out
module nibble_add4
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  assign {cout, s} = (NIBBLE_W+1)'(x) + (NIBBLE_W+1)'(y) + (NIBBLE_W+1)'(cin);

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - add/subtract sequencer sharing one nibble adder, LSB nibble first
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = $clog2(NIBBLES) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_co;

  nibble_add4 u_add4 (
    .x    (opa_q[NIBBLE_W-1:0]),
    .y    (opb_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_co)
  );

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // subtraction is a + ~b + 1: invert B here, the +1 rides in on the carry
          opa_d   = a;
          opb_d   = op_sub ? ~b : b;
          carry_d = op_sub;
          cnt_d   = '0;
          sa_d    = a[WIDTH-1];
          sb_d    = op_sub ? ~b[WIDTH-1] : b[WIDTH-1];
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        opa_d    = opa_q >> NIBBLE_W;
        opb_d    = opb_q >> NIBBLE_W;
        result_d = (result_q >> NIBBLE_W) | (WIDTH'(nib_s) << (WIDTH - NIBBLE_W));
        carry_d  = nib_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          cout_d  = nib_co;
          ovf_d   = (sa_q == sb_q) && (nib_s[NIBBLE_W-1] != sa_q);
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - directed and random checks of the serial adder at WIDTH 16 and 4
module tb_nibble_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s16, sub16, rdy16, bsy16, dn16, co16, ov16;
  logic [15:0] a16, b16, r16;
  logic        s4, sub4, rdy4, bsy4, dn4, co4, ov4;
  logic [3:0]  a4, b4, r4;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(s16), .op_sub(sub16), .a(a16), .b(b16),
    .ready(rdy16), .busy(bsy16), .done(dn16), .result(r16), .cout(co16), .overflow(ov16)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4), .op_sub(sub4), .a(a4), .b(b4),
    .ready(rdy4), .busy(bsy4), .done(dn4), .result(r4), .cout(co4), .overflow(ov4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [15:0] a, input logic [15:0] b,
                       input logic sub);
    if (w == 16) begin
      s16 = st; a16 = a; b16 = b; sub16 = sub;
    end else begin
      s4 = st; a4 = a[3:0]; b4 = b[3:0]; sub4 = sub;
    end
  endtask

  function automatic logic g_done(input int w);  return (w == 16) ? dn16 : dn4;   endfunction
  function automatic logic g_ready(input int w); return (w == 16) ? rdy16 : rdy4; endfunction
  function automatic logic g_busy(input int w);  return (w == 16) ? bsy16 : bsy4; endfunction
  function automatic logic g_cout(input int w);  return (w == 16) ? co16 : co4;   endfunction
  function automatic logic g_ovf(input int w);   return (w == 16) ? ov16 : ov4;   endfunction
  function automatic logic [15:0] g_res(input int w);
    return (w == 16) ? r16 : {12'h000, r4};
  endfunction

  // Plain integer arithmetic: unsigned wrap, borrow as a>=b, signed range check
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b, input logic sub,
                       output logic [15:0] r, output logic c, output logic o);
    int mask, half, ua, ub, sa, sb, sr;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    ua   = int'(a) & mask;
    ub   = int'(b) & mask;
    r    = 16'((sub ? ua - ub : ua + ub) & mask);
    c    = sub ? (ua >= ub) : (((ua + ub) >> w) != 0);
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    sr   = sub ? sa - sb : sa + sb;
    o    = (sr >= half) || (sr < -half);
  endtask

  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input bit glitch, input string tag);
    logic [15:0] er;
    logic        ec, eo;
    int          edges;
    bit          seen;
    model(w, a, b, sub, er, ec, eo);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(g_ready(w)), 32'd1);
    drive(w, 1'b1, a, b, sub);
    edges = 0;
    seen  = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) begin
        chk({tag, "_busy"}, 32'({g_busy(w), g_ready(w)}), 32'b10);
        drive(w, 1'b0, ~a, ~b, ~sub);
      end else if (glitch && edges == 2) begin
        drive(w, 1'b1, a ^ 16'h5a5a, b ^ 16'h0f0f, ~sub);
      end else begin
        drive(w, 1'b0, ~a, ~b, ~sub);
      end
      if (g_done(w)) seen = 1;
    end
    drive(w, 1'b0, 16'h0, 16'h0, 1'b0);
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, 32'(edges), 32'(w / 4 + 1));
    chk({tag, "_res"}, 32'(g_res(w)), 32'(er));
    chk({tag, "_cout"}, 32'(g_cout(w)), 32'(ec));
    chk({tag, "_ovf"}, 32'(g_ovf(w)), 32'(eo));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'({g_done(w), g_ready(w)}), 32'b01);
    chk({tag, "_hold"}, 32'({g_res(w), g_cout(w), g_ovf(w)}), 32'({er, ec, eo}));
    if (glitch) begin
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        chk({tag, "_nodup"}, 32'(g_done(w)), 32'd0);
      end
    end
  endtask

  initial begin
    int last_done, n_done, cyc;
    logic [15:0] er;
    logic        ec, eo;

    rst = 1'b1;
    drive(16, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(4, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst16", 32'({rdy16, bsy16, dn16, r16, co16, ov16}), 32'({3'b100, 16'h0, 2'b00}));
    chk("rst4", 32'({rdy4, bsy4, dn4, r4, co4, ov4}), 32'({3'b100, 4'h0, 2'b00}));
    rst = 1'b0;

    run_op(16, 16'h1234, 16'h4321, 1'b0, 0, "add_5555");
    run_op(16, 16'hFFFF, 16'h0001, 1'b0, 0, "add_ripple");
    run_op(16, 16'h0005, 16'h0007, 1'b1, 0, "sub_neg");
    run_op(16, 16'h8000, 16'h0001, 1'b1, 0, "sub_ovf");
    run_op(16, 16'h7FFF, 16'h0001, 1'b0, 1, "add_ovf_glitch");

    // abort two cycles into RUN
    @(negedge clk);
    drive(16, 1'b1, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(16, 1'b0, 16'h0, 16'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", 32'({rdy16, bsy16, dn16}), 32'b100);
    chk("abort_out", 32'({r16, co16, ov16}), 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_nodone", 32'(dn16), 32'd0);
    end
    run_op(16, 16'h00FF, 16'h0F01, 1'b0, 0, "post_abort");

    run_op(4, 16'h0009, 16'h0008, 1'b0, 0, "w4_add");
    run_op(4, 16'h0003, 16'h0008, 1'b1, 0, "w4_sub");

    for (int i = 0; i < 16; i++)
      run_op(16, 16'($urandom), 16'($urandom), 1'($urandom), 0, "rand16");
    for (int i = 0; i < 8; i++)
      run_op(4, 16'($urandom_range(15)), 16'($urandom_range(15)), 1'($urandom), 0, "rand4");

    // continuous start on the 4-bit instance
    model(4, 16'h0003, 16'h0006, 1'b0, er, ec, eo);
    @(negedge clk);
    drive(4, 1'b1, 16'h0003, 16'h0006, 1'b0);
    last_done = -1;
    n_done    = 0;
    for (cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (dn4) begin
        chk("b2b_res", 32'({r4, co4, ov4}), 32'({er[3:0], ec, eo}));
        if (last_done >= 0) chk("b2b_spacing", 32'(cyc - last_done), 32'd3);
        last_done = cyc;
        n_done++;
      end
    end
    drive(4, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("b2b_count", 32'(n_done), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
